// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB; outputs are combinational from state plus inputs.
// Stalls in FETCH/MEM on cache ready; optional wait timeout, illegal-op pulse, saturating stall counter.
module multicycle_controller #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_read,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               lh,
  output logic               sh,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               to_reg31,
  output logic               mem_to_reg,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_XOR = 4'b0011, OP_SLL = 4'b0100, OP_SRL = 4'b0101,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100,
                         OP_JMP = 4'b1111;

  // Counter only needs to reach TIMEOUT-1: the abort fires on the cycle that would make it TIMEOUT.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLIM   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_t             cur, nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               waiting, timeout_hit;

  logic       legal, r_type, is_load, is_store, is_half, is_link;
  logic       is_jr, is_j, is_br, is_bne, uses_imm;
  logic [3:0] aop;

  assign state = cur;

  always_comb begin
    legal    = 1'b1;
    r_type   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_link  = 1'b0;
    is_jr    = 1'b0;
    is_j     = 1'b0;
    is_br    = 1'b0;
    is_bne   = 1'b0;
    uses_imm = 1'b0;
    aop      = OP_AND;
    case (opcode)
      6'b000000: begin
        r_type = 1'b1;
        case (funct)
          6'b100000: aop = OP_ADD;
          6'b100010: aop = OP_SUB;
          6'b100100: aop = OP_AND;
          6'b100101: aop = OP_OR;
          6'b100110: aop = OP_XOR;
          6'b100111: aop = OP_NOR;
          6'b101010: aop = OP_SLT;
          6'b000000: aop = OP_SLL;
          6'b000010: aop = OP_SRL;
          6'b001000: begin aop = OP_JMP; is_jr = 1'b1; end
          6'b001001: begin aop = OP_JMP; is_jr = 1'b1; is_link = 1'b1; end
          default:   legal = 1'b0;
        endcase
      end
      6'b001000: begin aop = OP_ADD; uses_imm = 1'b1; end
      6'b001100: begin aop = OP_AND; uses_imm = 1'b1; end
      6'b001010: begin aop = OP_SLT; uses_imm = 1'b1; end
      6'b100011: begin aop = OP_ADD; uses_imm = 1'b1; is_load = 1'b1; end
      6'b100001: begin aop = OP_ADD; uses_imm = 1'b1; is_load = 1'b1; is_half = 1'b1; end
      6'b101011: begin aop = OP_ADD; uses_imm = 1'b1; is_store = 1'b1; end
      6'b101001: begin aop = OP_ADD; uses_imm = 1'b1; is_store = 1'b1; is_half = 1'b1; end
      6'b000100: begin aop = OP_SUB; is_br = 1'b1; end
      6'b000101: begin aop = OP_SUB; is_br = 1'b1; is_bne = 1'b1; end
      6'b000010: begin aop = OP_JMP; is_j = 1'b1; end
      6'b000011: begin aop = OP_JMP; is_j = 1'b1; is_link = 1'b1; end
      default:   legal = 1'b0;
    endcase
  end

  assign waiting     = ((cur == S_FETCH) && !imem_ready) || ((cur == S_MEM) && !dmem_ready);
  assign timeout_hit = (TIMEOUT != 0) && waiting && (wait_cnt == WAIT_W'(TLIM));

  always_comb begin
    nxt         = cur;
    imem_read   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    lh          = 1'b0;
    sh          = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    to_reg31    = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src     = 1'b0;
    alu_op      = '0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    case (cur)
      S_RESET: nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          imem_read = 1'b1;
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nxt       = S_DECODE;
        end else if (timeout_hit) begin
          mem_timeout = 1'b1;
        end else begin
          imem_read = 1'b1;
        end
      end
      S_DECODE: begin
        if (legal) begin
          nxt = S_EXEC;
        end else begin
          illegal = 1'b1;
          nxt     = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_op  = ALUOP_W'(aop);
        alu_src = uses_imm;
        reg_dst = r_type && !is_jr;
        if (is_br) begin
          pc_src   = 2'b01;
          pc_write = is_bne ? !zero : zero;
          nxt      = S_FETCH;
        end else if (is_j) begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
          nxt      = is_link ? S_WB : S_FETCH;
        end else if (is_jr) begin
          pc_src   = 2'b11;
          pc_write = 1'b1;
          nxt      = is_link ? S_WB : S_FETCH;
        end else if (is_load || is_store) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        alu_op = ALUOP_W'(OP_ADD);
        if (timeout_hit) begin
          mem_timeout = 1'b1;
          nxt         = S_FETCH;
        end else begin
          mem_read  = is_load;
          mem_write = is_store;
          lh        = is_load && is_half;
          sh        = is_store && is_half;
          if (dmem_ready) nxt = is_load ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        reg_dst    = r_type && !is_jr;
        to_reg31   = is_link;
        nxt        = S_FETCH;
      end
      default: nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= S_RESET;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      cur <= nxt;
      if (waiting && !timeout_hit && (TIMEOUT != 0)) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                           wait_cnt <= '0;
      if (waiting && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
